trackball_quad_encoder: RTL and testbench

//  Transmit side of the trackball interface: turns MiSTer joystick directions and PS/2 mouse deltas into
//  two quadrature pairs (X, Y) for the CCastles trackball counters. Sits in emu between hps_io and

---
 rtl/trackball_quad_encoder_pkg.sv | 37 +++
 rtl/trackball_quad_encoder_quad_axis.sv | 90 +++++++++
 rtl/trackball_quad_encoder.sv | 100 ++++++++++
 tb/tb_trackball_quad_encoder.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/trackball_quad_encoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trackball_pkg
//  Description : Shared constants and helpers for the trackball quadrature
//                encoder: gray lookup, pending-count limit, saturation.
//  Revision    : 1.0  initial release
// ============================================================================
package trackball_pkg;

    // Default accumulator width and its symmetric magnitude limit
    localparam int PEND_W_DEFAULT = 10;
    localparam int PEND_MAX       = (1 << (PEND_W_DEFAULT - 1)) - 1;

    // Phase 0..3 to {A,B}; walking forward gives 00->01->11->10
    localparam logic [1:0] GRAY_SEQ [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    // Largest magnitude a signed accumulator of the given width may hold.
    // The most negative code is excluded so the range stays symmetric.
    function automatic int pend_max(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

    // Clamp a sign-extended sum into [-lim, +lim]
    function automatic logic signed [31:0] sat_pend(input logic signed [31:0] sum,
                                                    input int                 lim);
        logic signed [31:0] res;
        if (sum > lim)
            res = lim;
        else if (sum < -lim)
            res = -lim;
        else
            res = sum;
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/trackball_quad_encoder_quad_axis.sv
`default_nettype none
// ============================================================================
//  Module      : quad_axis
//  Description : One trackball axis. Accumulates mouse and joystick motion
//                into a saturating signed pending count and drains it one
//                gray-code step per tick onto a registered {A,B} pair.
//  Revision    : 1.0  initial release
// ============================================================================
module quad_axis
    import trackball_pkg::*;
#(
    parameter int PEND_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              tick_i,
    input  logic              joy_evt_i,
    input  logic              joy_pos_i,
    input  logic              joy_neg_i,
    input  logic              stb_i,
    input  logic signed [8:0] delta_i,
    output logic [1:0]        quad_o,
    output logic              pend_nz_o
);

    // Two guard bits: pending + delta + joy - step can never wrap
    localparam int SUM_W = PEND_W + 2;
    localparam int LIM   = pend_max(PEND_W);

    logic signed [PEND_W-1:0] pend_q, pend_d;
    logic [1:0]               phase_q, phase_d;
    logic [1:0]               quad_q, quad_d;

    logic                     step_up, step_dn;
    logic signed [SUM_W-1:0]  w_pend_ext, w_delta, w_joy, w_step, w_sum;
    logic signed [31:0]       w_sum32;

    // Next pending count, phase and gray output; all three sources apply together
    always_comb begin
        step_up    = en_i && tick_i && !pend_q[PEND_W-1] && (pend_q != '0);
        step_dn    = en_i && tick_i &&  pend_q[PEND_W-1];

        w_pend_ext = {{2{pend_q[PEND_W-1]}}, pend_q};
        w_delta    = stb_i ? {{(SUM_W-9){delta_i[8]}}, delta_i} : '0;

        w_joy      = '0;
        if (joy_evt_i && joy_pos_i && !joy_neg_i)
            w_joy = SUM_W'(1);
        else if (joy_evt_i && joy_neg_i && !joy_pos_i)
            w_joy = '1;

        w_step     = '0;
        if (step_up)
            w_step = SUM_W'(1);
        else if (step_dn)
            w_step = '1;

        w_sum      = w_pend_ext + w_delta + w_joy - w_step;
        w_sum32    = {{(32-SUM_W){w_sum[SUM_W-1]}}, w_sum};

        pend_d     = en_i ? PEND_W'(sat_pend(w_sum32, LIM)) : '0;

        phase_d    = phase_q;
        if (step_up)
            phase_d = phase_q + 2'd1;
        else if (step_dn)
            phase_d = phase_q - 2'd1;

        quad_d     = GRAY_SEQ[phase_d];
    end

    // Axis state; quad follows the new phase on the same edge the step is taken
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q  <= '0;
            phase_q <= 2'd0;
            quad_q  <= 2'b00;
        end else begin
            pend_q  <= pend_d;
            phase_q <= phase_d;
            quad_q  <= quad_d;
        end
    end

    assign quad_o    = quad_q;
    assign pend_nz_o = (pend_d != '0);

endmodule
`default_nettype wire

// File: rtl/trackball_quad_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : trackball_quad_encoder
//  Description : Converts joystick directions and PS/2 mouse deltas into
//                paced X/Y quadrature pairs for the trackball counters.
//  Revision    : 1.0  initial release
// ============================================================================
module trackball_quad_encoder #(
    parameter int TICK_DIV = 2000,
    parameter int JOY_DIV  = 4,
    parameter int PEND_W   = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              joy_r,
    input  logic              joy_l,
    input  logic              joy_d,
    input  logic              joy_u,
    input  logic              mouse_stb,
    input  logic signed [8:0] mouse_dx,
    input  logic signed [8:0] mouse_dy,
    output logic [1:0]        quad_x,
    output logic [1:0]        quad_y,
    output logic              busy
);

    localparam int TCNT_W = $clog2(TICK_DIV);
    localparam int JCNT_W = (JOY_DIV > 1) ? $clog2(JOY_DIV) : 1;

    logic [TCNT_W-1:0] tick_cnt_q;
    logic [JCNT_W-1:0] joy_cnt_q;
    logic              w_tick, w_joy_evt, w_stb;
    logic              w_nz_x, w_nz_y;
    logic              busy_q;

    assign w_tick    = en && (tick_cnt_q == TCNT_W'(TICK_DIV - 1));
    assign w_joy_evt = w_tick && (joy_cnt_q == JCNT_W'(JOY_DIV - 1));
    assign w_stb     = en && mouse_stb;

    // Step-rate divider, parked at zero while disabled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            tick_cnt_q <= '0;
        else if (!en || w_tick)
            tick_cnt_q <= '0;
        else
            tick_cnt_q <= tick_cnt_q + 1'b1;
    end

    // Joystick-rate divider counting step ticks
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            joy_cnt_q <= '0;
        else if (!en || w_joy_evt)
            joy_cnt_q <= '0;
        else if (w_tick)
            joy_cnt_q <= joy_cnt_q + 1'b1;
    end

    quad_axis #(.PEND_W(PEND_W)) u_axis_x (
        .clk_i     (clk),
        .rst_ni    (reset_n),
        .en_i      (en),
        .tick_i    (w_tick),
        .joy_evt_i (w_joy_evt),
        .joy_pos_i (joy_r),
        .joy_neg_i (joy_l),
        .stb_i     (w_stb),
        .delta_i   (mouse_dx),
        .quad_o    (quad_x),
        .pend_nz_o (w_nz_x)
    );

    quad_axis #(.PEND_W(PEND_W)) u_axis_y (
        .clk_i     (clk),
        .rst_ni    (reset_n),
        .en_i      (en),
        .tick_i    (w_tick),
        .joy_evt_i (w_joy_evt),
        .joy_pos_i (joy_d),
        .joy_neg_i (joy_u),
        .stb_i     (w_stb),
        .delta_i   (mouse_dy),
        .quad_o    (quad_y),
        .pend_nz_o (w_nz_y)
    );

    // Busy registered from next-state pending so it lines up with the accumulators
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            busy_q <= 1'b0;
        else
            busy_q <= w_nz_x || w_nz_y;
    end

    assign busy = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_trackball_quad_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_trackball_quad_encoder
//  Description : Directed self-checking bench for trackball_quad_encoder
//                (TICK_DIV=4, JOY_DIV=2, PEND_W=10).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_trackball_quad_encoder;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              en;
    logic              joy_r, joy_l, joy_d, joy_u;
    logic              mouse_stb;
    logic signed [8:0] mouse_dx, mouse_dy;
    logic [1:0]        quad_x, quad_y;
    logic              busy;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    // Edge tracking decoded from the quadrature outputs
    logic [1:0] prev_x = 2'b00;
    logic [1:0] prev_y = 2'b00;
    int x_cnt = 0, y_cnt = 0, x_pos = 0, y_pos = 0;
    int x_last_cyc = 0, x_prev_cyc = 0;

    trackball_quad_encoder #(.TICK_DIV(4), .JOY_DIV(2), .PEND_W(10)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .joy_r     (joy_r),
        .joy_l     (joy_l),
        .joy_d     (joy_d),
        .joy_u     (joy_u),
        .mouse_stb (mouse_stb),
        .mouse_dx  (mouse_dx),
        .mouse_dy  (mouse_dy),
        .quad_x    (quad_x),
        .quad_y    (quad_y),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk_vec(input string tag, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    function automatic int g2p(input logic [1:0] g);
        case (g)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    // Decode every output change into a signed step and check it is a single-bit move
    always @(posedge clk) begin
        int d;
        #1;
        if (!reset_n) begin
            prev_x = quad_x;
            prev_y = quad_y;
        end else begin
            if (quad_x != prev_x) begin
                chk_vec("x_one_bit", $countones(quad_x ^ prev_x), 1);
                d = (g2p(quad_x) - g2p(prev_x)) & 3;
                x_pos += (d == 1) ? 1 : -1;
                x_cnt++;
                x_prev_cyc = x_last_cyc;
                x_last_cyc = cyc;
                prev_x = quad_x;
            end
            if (quad_y != prev_y) begin
                chk_vec("y_one_bit", $countones(quad_y ^ prev_y), 1);
                d = (g2p(quad_y) - g2p(prev_y)) & 3;
                y_pos += (d == 1) ? 1 : -1;
                y_cnt++;
                prev_y = quad_y;
            end
        end
    end

    task automatic strobe(input int dx, input int dy);
        mouse_dx  = dx[8:0];
        mouse_dy  = dy[8:0];
        mouse_stb = 1'b1;
        @(negedge clk);
        mouse_stb = 1'b0;
        mouse_dx  = '0;
        mouse_dy  = '0;
    endtask

    task automatic wait_x(input int target, input int budget);
        int n = 0;
        while (x_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (x_cnt < target)
            chk_vec("x_edge_timeout", x_cnt, target);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk_vec(tag, int'(busy), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int bx, bp, by, byp;

        reset_n = 1'b0; en = 1'b1;
        joy_r = 0; joy_l = 0; joy_d = 0; joy_u = 0;
        mouse_stb = 0; mouse_dx = '0; mouse_dy = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk_vec("rst_quad_x", quad_x, 0);
        chk_vec("rst_quad_y", quad_y, 0);
        chk_vec("rst_busy",   busy,   0);
        repeat (5) @(negedge clk);

        // 1: dx=+3 -> three forward X edges 4 clk apart
        bx = x_cnt; bp = x_pos;
        strobe(3, 0);
        chk_vec("t1_busy_set", busy, 1);
        wait_x(bx + 2, 40);
        chk_vec("t1_busy_mid", busy, 1);
        chk_vec("t1_quad_mid", quad_x, 2'b11);
        wait_x(bx + 3, 40);
        chk_vec("t1_busy_end", busy, 0);
        chk_vec("t1_quad_end", quad_x, 2'b10);
        chk_vec("t1_spacing", x_last_cyc - x_prev_cyc, 4);
        chk_vec("t1_net", x_pos - bp, 3);

        // 2: dy=-2 then dy=+2
        by = y_cnt; byp = y_pos;
        strobe(0, -2);
        wait_idle("t2_idle_a", 40);
        chk_vec("t2_quad_a", quad_y, 2'b11);
        chk_vec("t2_net_a",  y_pos - byp, -2);
        strobe(0, 2);
        wait_idle("t2_idle_b", 40);
        chk_vec("t2_quad_b", quad_y, 2'b00);
        chk_vec("t2_net_b",  y_pos - byp, 0);
        chk_vec("t2_edges",  y_cnt - by, 4);

        // 3: joy_r for 16 ticks -> 8 steps; both keys -> nothing
        bx = x_cnt; bp = x_pos;
        joy_r = 1;
        repeat (64) @(negedge clk);
        joy_r = 0;
        wait_idle("t3_idle_a", 40);
        chk_vec("t3_net_r",  x_pos - bp, 8);
        chk_vec("t3_quad_r", quad_x, 2'b10);
        bx = x_cnt;
        joy_r = 1; joy_l = 1;
        repeat (64) @(negedge clk);
        joy_r = 0; joy_l = 0;
        chk_vec("t3_both_busy", busy, 0);
        chk_vec("t3_both_edges", x_cnt - bx, 0);

        // Y joystick: down 4 ticks -> +2, up 4 ticks -> -2
        byp = y_pos;
        joy_d = 1;
        repeat (16) @(negedge clk);
        joy_d = 0;
        wait_idle("ty_idle_d", 40);
        chk_vec("ty_net_d",  y_pos - byp, 2);
        chk_vec("ty_quad_d", quad_y, 2'b11);
        joy_u = 1;
        repeat (16) @(negedge clk);
        joy_u = 0;
        wait_idle("ty_idle_u", 40);
        chk_vec("ty_net_u",  y_pos - byp, 0);

        // 4: saturation at +511 and -511
        for (int i = 0; i < 5; i++) begin
            mouse_dx = 9'sd255; mouse_stb = 1;
            @(negedge clk);
        end
        mouse_stb = 0; mouse_dx = '0;
        bx = x_cnt; bp = x_pos;
        wait_idle("t4_idle_pos", 4000);
        chk_vec("t4_steps_pos", x_cnt - bx, 511);
        chk_vec("t4_net_pos",   x_pos - bp, 511);
        strobe(-256, 0);
        strobe(-244, 0);
        strobe(-256, 0);
        bx = x_cnt; bp = x_pos;
        wait_idle("t4_idle_neg", 4000);
        chk_vec("t4_steps_neg", x_cnt - bx, 511);
        chk_vec("t4_net_neg",   x_pos - bp, -511);

        // 5: strobe +1 on the tick where pending is +1
        bp = x_pos;
        strobe(2, 0);
        wait_x(x_cnt + 1, 40);
        repeat (3) @(negedge clk);
        strobe(1, 0);
        chk_vec("t5_net_mid", x_pos - bp, 2);
        chk_vec("t5_busy_mid", busy, 1);
        wait_idle("t5_idle", 40);
        chk_vec("t5_net_end", x_pos - bp, 3);

        // 6: disable with pending, then async reset mid-motion
        strobe(40, 0);
        repeat (10) @(negedge clk);
        chk_vec("t6_busy_pre", busy, 1);
        bx = x_cnt; bp = quad_x;
        en = 0;
        @(negedge clk);
        chk_vec("t6_busy_off", busy, 0);
        repeat (20) @(negedge clk);
        chk_vec("t6_frozen_edges", x_cnt - bx, 0);
        chk_vec("t6_frozen_quad",  quad_x, bp);
        en = 1;
        repeat (20) @(negedge clk);
        chk_vec("t6_resume_busy",  busy, 0);
        chk_vec("t6_resume_edges", x_cnt - bx, 0);

        strobe(10, -10);
        begin
            int n = 0;
            while (!(quad_x != 2'b00 && busy === 1'b1) && n < 40) begin
                @(negedge clk);
                n++;
            end
            if (n >= 40)
                chk_vec("t6_motion_timeout", n, 0);
        end
        @(posedge clk);
        #2 reset_n = 0;
        #1;
        chk_vec("t6_rst_quad_x", quad_x, 0);
        chk_vec("t6_rst_quad_y", quad_y, 0);
        chk_vec("t6_rst_busy",   busy,   0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        bx = x_cnt; by = y_cnt;
        repeat (40) @(negedge clk);
        chk_vec("t6_post_quad_x", quad_x, 0);
        chk_vec("t6_post_quad_y", quad_y, 0);
        chk_vec("t6_post_busy",   busy,   0);
        chk_vec("t6_post_edges",  (x_cnt - bx) + (y_cnt - by), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
`default_nettype wire
